// File: rtl/gesture_bus_pkg.sv
// Shared definitions for the gesture DAC bus: slot ids used by both the
// transmit and receive sides, plus the receiver's frame-tracking state encoding.
package gesture_bus_pkg;

    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_ROLL  = 2'd1;
    localparam logic [1:0] SLOT_HOVER = 2'd2;
    localparam logic [1:0] SLOT_PITCH = 2'd3;

    // strobe + 2-bit slot id + 8-bit data
    localparam int BUS_W = 11;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_EXP1 = 2'd1,
        ST_EXP2 = 2'd2,
        ST_EXP3 = 2'd3
    } rx_state_e;

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous input bits.
// Every bit sees the same chain depth, so the bundle stays aligned.
module bus_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 11
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    // Shift the bundle through the synchronizer chain
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dac_bus_receiver.sv
// Receive end of the time-multiplexed gesture DAC bus: demultiplexes idle/roll/
// hover/pitch slots, commits whole frames atomically and watches link health.
module dac_bus_receiver
    import gesture_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 4,
    parameter int TIMEOUT     = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_signal,
    input  logic [1:0] gest_select,
    input  logic [7:0] gest_out,
    output logic [7:0] roll,
    output logic [7:0] hover,
    output logic [7:0] pitch,
    output logic       data_valid,
    output logic       frame_strobe,
    output logic       seq_error,
    output logic       link_lost
);

    localparam int PCW = $clog2(MIN_PULSE + 1);

    logic [BUS_W-1:0] w_sync;
    logic             w_ws;
    logic [1:0]       w_sel;
    logic [7:0]       w_dat;
    logic             w_cap;
    logic             w_idle_zero;
    logic             w_to_expire;

    logic [PCW-1:0]   r_pcnt;
    logic             r_ws_prev;
    logic [1:0]       r_sel_hold;
    logic [7:0]       r_dat_hold;
    logic             r_cap_vld;
    logic [1:0]       r_cap_sel;
    logic [7:0]       r_cap_dat;
    logic [15:0]      r_to_cnt;
    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [7:0]       r_sh_roll;
    logic [7:0]       r_sh_hover;
    logic             w_load_roll;
    logic             w_load_hover;
    logic             w_commit;
    logic             w_seq_err;

    logic [7:0]       r_roll;
    logic [7:0]       r_hover;
    logic [7:0]       r_pitch;
    logic             r_data_valid;
    logic             r_frame_strobe;
    logic             r_seq_error;
    logic             r_link_lost;

    bus_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (BUS_W)
    ) u_bus_sync (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     ({write_signal, gest_select, gest_out}),
        .o_q     (w_sync)
    );

    assign w_ws  = w_sync[10];
    assign w_sel = w_sync[9:8];
    assign w_dat = w_sync[7:0];

    // A strobe counts only if it stayed high for at least MIN_PULSE cycles
    assign w_cap       = r_ws_prev & ~w_ws & (r_pcnt >= PCW'(MIN_PULSE));
    assign w_idle_zero = (r_cap_sel == SLOT_IDLE) && (r_cap_dat == 8'h00);
    // Capture on the same cycle overrides an expiring timeout
    assign w_to_expire = ~r_cap_vld & (r_to_cnt == 16'(TIMEOUT - 1));

    // Strobe qualification and capture of the slot seen on the last high cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcnt     <= '0;
            r_ws_prev  <= 1'b0;
            r_sel_hold <= 2'd0;
            r_dat_hold <= 8'h00;
            r_cap_vld  <= 1'b0;
            r_cap_sel  <= 2'd0;
            r_cap_dat  <= 8'h00;
        end else begin
            r_ws_prev <= w_ws;
            if (w_ws) begin
                if (r_pcnt != PCW'(MIN_PULSE)) begin
                    r_pcnt <= r_pcnt + PCW'(1);
                end
                r_sel_hold <= w_sel;
                r_dat_hold <= w_dat;
            end else begin
                r_pcnt <= '0;
            end
            r_cap_vld <= w_cap;
            if (w_cap) begin
                r_cap_sel <= r_sel_hold;
                r_cap_dat <= r_dat_hold;
            end
        end
    end

    // Frame-ordering next state; any bad slot aborts, a clean idle resyncs in place
    always_comb begin
        w_state_nxt  = r_state;
        w_load_roll  = 1'b0;
        w_load_hover = 1'b0;
        w_commit     = 1'b0;
        w_seq_err    = 1'b0;
        if (r_cap_vld) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_idle_zero) begin
                        w_state_nxt = ST_EXP1;
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_EXP1: begin
                    if (r_cap_sel == SLOT_ROLL) begin
                        w_load_roll = 1'b1;
                        w_state_nxt = ST_EXP2;
                    end else begin
                        w_seq_err   = 1'b1;
                        w_state_nxt = w_idle_zero ? ST_EXP1 : ST_HUNT;
                    end
                end
                ST_EXP2: begin
                    if (r_cap_sel == SLOT_HOVER) begin
                        w_load_hover = 1'b1;
                        w_state_nxt  = ST_EXP3;
                    end else begin
                        w_seq_err   = 1'b1;
                        w_state_nxt = w_idle_zero ? ST_EXP1 : ST_HUNT;
                    end
                end
                ST_EXP3: begin
                    if (r_cap_sel == SLOT_PITCH) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_seq_err   = 1'b1;
                        w_state_nxt = w_idle_zero ? ST_EXP1 : ST_HUNT;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end else if (w_to_expire) begin
            w_state_nxt = ST_HUNT;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, shadow, committed outputs and link watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_HUNT;
            r_sh_roll      <= 8'h00;
            r_sh_hover     <= 8'h00;
            r_roll         <= 8'h00;
            r_hover        <= 8'h00;
            r_pitch        <= 8'h00;
            r_data_valid   <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_seq_error    <= 1'b0;
            r_link_lost    <= 1'b0;
            r_to_cnt       <= 16'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_frame_strobe <= w_commit;
            r_seq_error    <= w_seq_err;

            if (w_seq_err) begin
                r_sh_roll  <= 8'h00;
                r_sh_hover <= 8'h00;
            end else if (w_load_roll) begin
                r_sh_roll <= r_cap_dat;
            end else if (w_load_hover) begin
                r_sh_hover <= r_cap_dat;
            end

            if (w_commit) begin
                r_roll       <= r_sh_roll;
                r_hover      <= r_sh_hover;
                r_pitch      <= r_cap_dat;
                r_data_valid <= 1'b1;
                r_link_lost  <= 1'b0;
            end else if (w_to_expire) begin
                r_data_valid <= 1'b0;
                r_link_lost  <= 1'b1;
            end

            if (r_cap_vld) begin
                r_to_cnt <= 16'd0;
            end else if (r_to_cnt != 16'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign roll         = r_roll;
    assign hover        = r_hover;
    assign pitch        = r_pitch;
    assign data_valid   = r_data_valid;
    assign frame_strobe = r_frame_strobe;
    assign seq_error    = r_seq_error;
    assign link_lost    = r_link_lost;

endmodule

// File: tb/tb_dac_bus_receiver.sv
// Directed self-checking bench for dac_bus_receiver: frames, glitches,
// ordering faults, timeout and reset are driven with hand-computed results.
module tb_dac_bus_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_PULSE   = 4;
    localparam int TIMEOUT     = 300;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_signal = 1'b0;
    logic [1:0] gest_select = 2'd0;
    logic [7:0] gest_out = 8'h00;
    logic [7:0] roll, hover, pitch;
    logic       data_valid, frame_strobe, seq_error, link_lost;

    int checks   = 0;
    int failures = 0;
    int n_fs     = 0;
    int n_se     = 0;
    int fs0, se0;

    dac_bus_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PULSE   (MIN_PULSE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write_signal (write_signal),
        .gest_select  (gest_select),
        .gest_out     (gest_out),
        .roll         (roll),
        .hover        (hover),
        .pitch        (pitch),
        .data_valid   (data_valid),
        .frame_strobe (frame_strobe),
        .seq_error    (seq_error),
        .link_lost    (link_lost)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (frame_strobe === 1'b1) n_fs <= n_fs + 1;
        if (seq_error === 1'b1)    n_se <= n_se + 1;
    end

    task automatic strobe(input logic [1:0] s, input logic [7:0] d, input int len);
        @(negedge clock);
        gest_select  = s;
        gest_out     = d;
        write_signal = 1'b1;
        repeat (len) @(negedge clock);
        write_signal = 1'b0;
    endtask

    task automatic send_slot(input logic [1:0] s, input logic [7:0] d);
        strobe(s, d, 8);
        repeat (6) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] r, input logic [7:0] h, input logic [7:0] p);
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, r);
        send_slot(2'd2, h);
        send_slot(2'd3, p);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({roll, hover, pitch} !== 24'h000000) begin
            failures++; $display("FAIL reset_values got=%h exp=000000", {roll, hover, pitch});
        end
        checks++;
        if ({data_valid, frame_strobe, seq_error, link_lost} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {data_valid, frame_strobe, seq_error, link_lost});
        end
    endtask

    task automatic test_clean_frame();
        se0 = n_se;
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h40);
        send_slot(2'd2, 8'h80);
        strobe(2'd3, 8'hC0, 8);
        repeat (SYNC_STAGES + 1) @(posedge clock);
        #1;
        checks++;
        if ({frame_strobe, pitch} !== {1'b0, 8'h00}) begin
            failures++; $display("FAIL latency_early got fs=%b pitch=%h exp fs=0 pitch=00", frame_strobe, pitch);
        end
        @(posedge clock);
        #1;
        checks++;
        if (frame_strobe !== 1'b1) begin
            failures++; $display("FAIL latency_strobe got=%b exp=1", frame_strobe);
        end
        checks++;
        if ({roll, hover, pitch, data_valid} !== {8'h40, 8'h80, 8'hC0, 1'b1}) begin
            failures++; $display("FAIL clean_frame got=%h %h %h dv=%b exp=40 80 c0 dv=1", roll, hover, pitch, data_valid);
        end
        @(posedge clock);
        #1;
        checks++;
        if (frame_strobe !== 1'b0) begin
            failures++; $display("FAIL strobe_one_cycle got=%b exp=0", frame_strobe);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (n_se - se0 !== 0) begin
            failures++; $display("FAIL clean_no_seq got=%0d exp=0", n_se - se0);
        end
    endtask

    task automatic test_glitch();
        fs0 = n_fs; se0 = n_se;
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h41);
        strobe(2'd2, 8'hFF, 2);
        repeat (6) @(negedge clock);
        strobe(2'd2, 8'hEE, MIN_PULSE - 1);
        repeat (6) @(negedge clock);
        send_slot(2'd2, 8'h80);
        strobe(2'd3, 8'hC1, MIN_PULSE);
        repeat (6) @(negedge clock);
        checks++;
        if ({roll, hover, pitch} !== {8'h41, 8'h80, 8'hC1}) begin
            failures++; $display("FAIL glitch_frame got=%h %h %h exp=41 80 c1", roll, hover, pitch);
        end
        checks++;
        if ((n_fs - fs0) !== 1 || (n_se - se0) !== 0) begin
            failures++; $display("FAIL glitch_pulses got fs=%0d se=%0d exp fs=1 se=0", n_fs - fs0, n_se - se0);
        end
    endtask

    task automatic test_out_of_order();
        fs0 = n_fs; se0 = n_se;
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h99);
        send_slot(2'd3, 8'h98);
        checks++;
        if ((n_se - se0) !== 1 || (n_fs - fs0) !== 0) begin
            failures++; $display("FAIL ooo_pulses got se=%0d fs=%0d exp se=1 fs=0", n_se - se0, n_fs - fs0);
        end
        checks++;
        if ({roll, hover, pitch} !== {8'h41, 8'h80, 8'hC1}) begin
            failures++; $display("FAIL ooo_hold got=%h %h %h exp=41 80 c1", roll, hover, pitch);
        end
        send_frame(8'h01, 8'h02, 8'h03);
        checks++;
        if ({roll, hover, pitch, data_valid} !== {8'h01, 8'h02, 8'h03, 1'b1}) begin
            failures++; $display("FAIL ooo_recover got=%h %h %h dv=%b exp=01 02 03 dv=1", roll, hover, pitch, data_valid);
        end
    endtask

    task automatic test_idle_corrupt();
        fs0 = n_fs; se0 = n_se;
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h55);
        send_slot(2'd0, 8'h05);
        send_slot(2'd1, 8'h56);
        send_slot(2'd2, 8'h57);
        send_slot(2'd3, 8'h58);
        checks++;
        if ((n_se - se0) !== 1 || (n_fs - fs0) !== 0) begin
            failures++; $display("FAIL idle_corrupt_pulses got se=%0d fs=%0d exp se=1 fs=0", n_se - se0, n_fs - fs0);
        end
        checks++;
        if ({roll, hover, pitch} !== {8'h01, 8'h02, 8'h03}) begin
            failures++; $display("FAIL idle_corrupt_hold got=%h %h %h exp=01 02 03", roll, hover, pitch);
        end
    endtask

    task automatic test_resync();
        fs0 = n_fs; se0 = n_se;
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h61);
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'h71);
        send_slot(2'd2, 8'h72);
        send_slot(2'd3, 8'h73);
        checks++;
        if ((n_se - se0) !== 1 || (n_fs - fs0) !== 1) begin
            failures++; $display("FAIL resync_pulses got se=%0d fs=%0d exp se=1 fs=1", n_se - se0, n_fs - fs0);
        end
        checks++;
        if ({roll, hover, pitch} !== {8'h71, 8'h72, 8'h73}) begin
            failures++; $display("FAIL resync_frame got=%h %h %h exp=71 72 73", roll, hover, pitch);
        end
    endtask

    task automatic test_timeout();
        repeat (TIMEOUT - 30) @(negedge clock);
        checks++;
        if ({link_lost, data_valid} !== 2'b01) begin
            failures++; $display("FAIL timeout_early got ll,dv=%b exp=01", {link_lost, data_valid});
        end
        repeat (50) @(negedge clock);
        checks++;
        if ({link_lost, data_valid} !== 2'b10) begin
            failures++; $display("FAIL timeout_expired got ll,dv=%b exp=10", {link_lost, data_valid});
        end
        checks++;
        if ({roll, hover, pitch} !== {8'h71, 8'h72, 8'h73}) begin
            failures++; $display("FAIL timeout_hold got=%h %h %h exp=71 72 73", roll, hover, pitch);
        end
        send_frame(8'h11, 8'h22, 8'h33);
        checks++;
        if ({link_lost, data_valid, roll, hover, pitch} !== {1'b0, 1'b1, 8'h11, 8'h22, 8'h33}) begin
            failures++; $display("FAIL timeout_recover got ll=%b dv=%b %h %h %h exp ll=0 dv=1 11 22 33",
                                 link_lost, data_valid, roll, hover, pitch);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_slot(2'd0, 8'h00);
        send_slot(2'd1, 8'hA1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({roll, hover, pitch, data_valid, link_lost} !== 26'd0) begin
            failures++; $display("FAIL midreset_clear got=%h %h %h dv=%b ll=%b exp all 0", roll, hover, pitch, data_valid, link_lost);
        end
        fs0 = n_fs;
        send_slot(2'd2, 8'hA2);
        send_slot(2'd3, 8'hA3);
        checks++;
        if ((n_fs - fs0) !== 0 || {roll, hover, pitch, data_valid} !== 25'd0) begin
            failures++; $display("FAIL midreset_no_commit got fs=%0d %h %h %h dv=%b exp fs=0 00 00 00 dv=0",
                                 n_fs - fs0, roll, hover, pitch, data_valid);
        end
        send_frame(8'hB1, 8'hB2, 8'hB3);
        checks++;
        if ({roll, hover, pitch, data_valid} !== {8'hB1, 8'hB2, 8'hB3, 1'b1}) begin
            failures++; $display("FAIL midreset_fresh got=%h %h %h dv=%b exp=b1 b2 b3 dv=1", roll, hover, pitch, data_valid);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_out_of_order();
        test_idle_corrupt();
        test_resync();
        test_timeout();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
